// File: rtl/sd_cmd_resp_pkg.sv
// Shared constants, state encoding and helpers for the SD SPI-mode command/response block.
package sd_cmd_resp_pkg;

    localparam int FRAME_LEN = 48;
    localparam int R1_LEN    = 8;
    localparam int R37_LEN   = 40;

    localparam logic [5:0] CMD8  = 6'd8;
    localparam logic [5:0] CMD58 = 6'd58;

    localparam logic [39:0] RESP_FILL_DEFAULT = 40'hFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        READ = 3'd3,
        DONE = 3'd4
    } state_t;

    // CMD8 (R7) and CMD58 (R3) answer with R1 plus a 32-bit payload.
    function automatic logic is_long_index(input logic [5:0] idx);
        return (idx == CMD8) || (idx == CMD58);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 (x^7 + x^3 + 1, init 0) over the 40-bit {01, index, argument} word.
module sd_crc7 (
    input  logic [39:0] data,
    output logic [6:0]  crc
);

    function automatic logic [6:0] crc7_calc(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction

    assign crc = crc7_calc(data);

endmodule

// File: rtl/sd_cmd_resp.sv
// Sends one 48-bit SD SPI command frame on DI and captures the R1 or R3/R7 response from DO.
module sd_cmd_resp
    import sd_cmd_resp_pkg::*;
#(
    parameter int          TIMEOUT_CLKS = 64,
    parameter logic [39:0] RESP_FILL    = RESP_FILL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  index,
    input  logic [31:0] argument,
    input  logic        isStart,
    output logic        isBusy,
    output logic        isFinish,
    output logic        DI,
    input  logic        DO,
    output logic [39:0] response,
    output state_t      state
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [39:0]   crc_data;
    logic [6:0]    crc;
    logic [47:0]   shreg;
    logic [5:0]    bit_cnt;
    logic [TW-1:0] tcnt;
    logic [38:0]   rx;
    logic [5:0]    rem;
    logic          long_resp;

    assign crc_data = {2'b01, index, argument};

    sd_crc7 u_crc7 (
        .data (crc_data),
        .crc  (crc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            DI        <= 1'b1;
            isBusy    <= 1'b0;
            isFinish  <= 1'b0;
            response  <= RESP_FILL;
            shreg     <= '0;
            bit_cnt   <= '0;
            tcnt      <= '0;
            rx        <= '0;
            rem       <= '0;
            long_resp <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DI       <= 1'b1;
                    isBusy   <= 1'b0;
                    isFinish <= 1'b0;
                    if (isStart) begin
                        // The first frame bit goes out now; shreg holds the remaining 47 bits left-aligned.
                        DI        <= crc_data[39];
                        shreg     <= {crc_data[38:0], crc, 1'b1, 1'b1};
                        bit_cnt   <= 6'(FRAME_LEN - 1);
                        long_resp <= is_long_index(index);
                        isBusy    <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt != 6'd0) begin
                        DI      <= shreg[47];
                        shreg   <= {shreg[46:0], 1'b1};
                        bit_cnt <= bit_cnt - 6'd1;
                    end else begin
                        DI    <= 1'b1;
                        tcnt  <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    DI <= 1'b1;
                    if (!DO) begin
                        // This zero is already R1 bit 7, so only the remaining bits are counted.
                        rx    <= '0;
                        rem   <= long_resp ? 6'(R37_LEN - 1) : 6'(R1_LEN - 1);
                        state <= READ;
                    end else if (int'(tcnt) == TIMEOUT_CLKS - 1) begin
                        response <= RESP_FILL;
                        isFinish <= 1'b1;
                        state    <= DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                READ: begin
                    DI  <= 1'b1;
                    rx  <= {rx[37:0], DO};
                    rem <= rem - 6'd1;
                    if (rem == 6'd1) begin
                        response <= long_resp ? {rx[38:0], DO} : {32'h0, rx[6:0], DO};
                        isFinish <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    DI <= 1'b1;
                    if (!isStart) begin
                        isBusy   <= 1'b0;
                        isFinish <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    DI       <= 1'b1;
                    isBusy   <= 1'b0;
                    isFinish <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_resp.sv
// Bench for sd_cmd_resp: a per-transaction timeline model predicts every cycle's outputs.
module tb_sd_cmd_resp;
    import sd_cmd_resp_pkg::*;

    localparam int          TIMEOUT = 64;
    localparam logic [39:0] FILL    = 40'hFF_FFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [5:0]  index;
    logic [31:0] argument;
    logic        isStart;
    logic        isBusy;
    logic        isFinish;
    logic        DI;
    logic        DO;
    logic [39:0] response;
    state_t      state;

    int total;
    int bad;

    // {isBusy, isFinish, DI, response} expected after each rising edge
    logic [42:0] exp_q[$];
    logic [39:0] m_resp;
    logic [47:0] obs_frame;
    logic [1:0]  obs_bf;
    logic [42:0] cmp_e;
    logic [42:0] cmp_a;
    int          cyc;

    sd_cmd_resp #(
        .TIMEOUT_CLKS (TIMEOUT),
        .RESP_FILL    (FILL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .index    (index),
        .argument (argument),
        .isStart  (isStart),
        .isBusy   (isBusy),
        .isFinish (isFinish),
        .DI       (DI),
        .DO       (DO),
        .response (response),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] d;
        logic [6:0]  c;
        d = {2'b01, idx, arg};
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
            else             c = {c[5:0], 1'b0};
        end
        return {d, c, 1'b1};
    endfunction

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                cmp_e = exp_q.pop_front();
                cmp_a = {isBusy, isFinish, DI, response};
                total++;
                if (cmp_a !== cmp_e) begin
                    bad++;
                    $display("FAIL cycle %0d busy/fin/di/resp got %b/%b/%b/%h want %b/%b/%b/%h",
                             cyc, cmp_a[42], cmp_a[41], cmp_a[40], cmp_a[39:0],
                             cmp_e[42], cmp_e[41], cmp_e[40], cmp_e[39:0]);
                end
            end
        end
    endtask

    task automatic tick(input logic rs, input logic st, input logic [5:0] ti,
                        input logic [31:0] ta, input logic dob, input logic [42:0] e);
        @(negedge clk);
        reset    = rs;
        isStart  = st;
        index    = ti;
        argument = ta;
        DO       = dob;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle_tick();
        tick(1'b1, 1'b0, 6'($urandom), $urandom, 1'($urandom_range(0, 1)), {1'b0, 1'b0, 1'b1, m_resp});
    endtask

    // d = number of idle 1s before the start bit (>= TIMEOUT means no answer); rv = response bits.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int d,
                           input logic [39:0] rv, input int hold, input bit early, input int idle);
        logic [47:0] fr;
        logic [39:0] fin_resp;
        logic        dob;
        logic        st;
        logic        di_e;
        int          len;
        int          done_n;
        int          j;
        fr  = model_frame(idx, arg);
        len = (idx == 6'd8 || idx == 6'd58) ? 40 : 8;
        if (d >= TIMEOUT) begin
            done_n   = 48 + TIMEOUT;
            fin_resp = FILL;
        end else begin
            done_n   = 48 + d + len;
            fin_resp = (len == 40) ? rv : {32'h0, rv[7:0]};
        end
        obs_frame = '0;
        for (int n = 0; n <= done_n; n++) begin
            st = (n == 0) ? 1'b1 : !early;
            j  = n - 49;
            if (n < 49)                    dob = 1'($urandom_range(0, 1));
            else if (d >= TIMEOUT || j < d) dob = 1'b1;
            else                           dob = rv[len - 1 - (j - d)];
            di_e = (n < 48) ? fr[47 - n] : 1'b1;
            tick(1'b1, st, (n == 0) ? idx : 6'($urandom), (n == 0) ? arg : $urandom, dob,
                 {1'b1, n == done_n, di_e, (n == done_n) ? fin_resp : m_resp});
            if (n < 48) begin
                #1;
                obs_frame = {obs_frame[46:0], DI};
            end
            if (n == done_n) begin
                #1;
                obs_bf = {isBusy, isFinish};
            end
        end
        m_resp = fin_resp;
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                tick(1'b1, 1'b1, 6'($urandom), $urandom, 1'($urandom_range(0, 1)), {1'b1, 1'b1, 1'b1, m_resp});
            end
        end
        idle_tick();
        for (int k = 0; k < idle; k++) idle_tick();
    endtask

    initial begin
        logic [47:0] fr;
        logic [63:0] tmp;
        logic [39:0] rv;
        logic [5:0]  idx;
        int          r;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        reset    = 1'b0;
        isStart  = 1'b0;
        index    = '0;
        argument = '0;
        DO       = 1'b1;
        m_resp   = FILL;
        fork
            compare_loop();
        join_none

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0, '0, 1'b1, {1'b0, 1'b0, 1'b1, FILL});
        idle_tick();

        // Pin the frame model against known-good SD command frames
        check("model_cmd0",  model_frame(6'd0,  32'h0),         48'h40_0000_0000_95);
        check("model_cmd8",  model_frame(6'd8,  32'h1AA),       48'h48_0000_01AA_87);
        check("model_cmd55", model_frame(6'd55, 32'h0),         48'h77_0000_0000_65);
        check("model_cmd41", model_frame(6'd41, 32'h4000_0000), 48'h69_4000_0000_77);
        check("model_cmd58", model_frame(6'd58, 32'h0),         48'h7A_0000_0000_FD);

        run_cmd(6'd0, 32'h0, 8, 40'h01, 2, 1'b0, 1);
        check("cmd0_frame", obs_frame, 48'h40_0000_0000_95);
        check("cmd0_busy_fin", {46'h0, obs_bf}, 48'h3);
        check("cmd0_resp", {8'h0, response}, {8'h0, 40'h00_0000_0001});

        run_cmd(6'd8, 32'h1AA, 3, 40'h01_0000_01AA, 1, 1'b0, 0);
        check("cmd8_frame", obs_frame, 48'h48_0000_01AA_87);
        check("cmd8_resp", {8'h0, response}, {8'h0, 40'h01_0000_01AA});

        run_cmd(6'd55, 32'h0, 0, 40'h01, 0, 1'b0, 1);
        check("cmd55_frame", obs_frame, 48'h77_0000_0000_65);
        run_cmd(6'd41, 32'h4000_0000, 5, 40'h00, 0, 1'b0, 0);
        check("cmd41_frame", obs_frame, 48'h69_4000_0000_77);
        check("cmd41_resp", {8'h0, response}, 48'h0);
        run_cmd(6'd58, 32'h0, 2, 40'h00_C0FF_8000, 0, 1'b0, 0);
        check("cmd58_frame", obs_frame, 48'h7A_0000_0000_FD);
        check("cmd58_resp", {8'h0, response}, {8'h0, 40'h00_C0FF_8000});

        // No answer from the card
        run_cmd(6'd55, 32'h0, TIMEOUT, 40'h0, 0, 1'b0, 1);
        check("timeout_busy_fin", {46'h0, obs_bf}, 48'h3);
        check("timeout_resp", {8'h0, response}, {8'h0, FILL});

        // Long DONE hold, then a new frame on the edge right after returning to IDLE
        run_cmd(6'd0, 32'h0, 1, 40'h01, 20, 1'b0, 0);
        run_cmd(6'd0, 32'h0, 0, 40'h01, 0, 1'b0, 1);
        check("rerun_frame", obs_frame, 48'h40_0000_0000_95);

        // Reset in the middle of the command frame
        fr = model_frame(6'd0, 32'h0);
        for (int n = 0; n <= 20; n++) begin
            tick(1'b1, 1'b1, '0, '0, 1'($urandom_range(0, 1)), {1'b1, 1'b0, fr[47 - n], m_resp});
        end
        tick(1'b0, 1'b1, '0, '0, 1'b1, {1'b0, 1'b0, 1'b1, FILL});
        m_resp = FILL;
        idle_tick();
        run_cmd(6'd0, 32'h0, 4, 40'h01, 0, 1'b0, 0);
        check("post_reset_resp", {8'h0, response}, {8'h0, 40'h00_0000_0001});

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      idx = 6'd8;
            else if (r < 4) idx = 6'd58;
            else            idx = 6'($urandom);
            tmp = {$urandom, $urandom};
            if (idx == 6'd8 || idx == 6'd58) rv = {1'b0, tmp[38:0]};
            else                             rv = {32'h0, 1'b0, tmp[6:0]};
            run_cmd(idx, $urandom, $urandom_range(0, 75), rv, $urandom_range(0, 3),
                    1'($urandom_range(0, 3) == 0), $urandom_range(0, 2));
        end

        idle_tick();
        @(negedge clk);
        check("queue_drained", 48'(exp_q.size()), 48'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
